// File: rtl/data_sram_resp.sv
// data_sram_resp: 32-bit word SRAM with a 1-cycle registered read port and a config-register window.
// Optional feature: define CONFREG_TIMER_EN to build the free-running TIMER register at offset 0x000C.
module data_sram_resp #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] CONF_BASE = 32'hBFAF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   input  logic [7:0]  switch
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   // Config-register word offsets (addr[15:2]).
   localparam logic [13:0] OffLed     = 14'h0;
   localparam logic [13:0] OffSwitch  = 14'h1;
   localparam logic [13:0] OffNum     = 14'h2;
   localparam logic [13:0] OffTimer   = 14'h3;
   localparam logic [13:0] OffScratch = 14'h4;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   logic                conf_hit;
   logic [13:0]         conf_off;
   logic [ADDR_W-1:0]   ram_idx;
   logic                req_wr;
   logic                ram_wr;
   logic                conf_wr;
   logic                unused_addr;

   assign conf_hit    = (data_sram_addr[31:16] == CONF_BASE[31:16]);
   assign conf_off    = data_sram_addr[15:2];
   assign ram_idx     = data_sram_addr[ADDR_W+1:2];
   assign unused_addr = ^data_sram_addr[1:0];

   // A request coinciding with reset is dropped entirely.
   assign req_wr  = data_sram_en && (data_sram_we != 4'b0000) && !reset;
   assign ram_wr  = req_wr && !conf_hit;
   assign conf_wr = req_wr && conf_hit;

   // ---------------------------------------------------------------- RAM
   logic [31:0] mem [Depth];
   logic [31:0] ram_rdata;

   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (data_sram_we[b]) mem[ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
         end
      end
   end

   assign ram_rdata = mem[ram_idx];

   // ---------------------------------------------------------------- config registers
   logic [15:0] led_q, led_d;
   logic [31:0] num_q, num_d;
   logic [31:0] scratch_q, scratch_d;
   logic [7:0]  sw_meta_q, sw_sync_q;
   logic [31:0] conf_rdata;

`ifdef CONFREG_TIMER_EN
   logic [31:0] timer_q, timer_d;

   // Written bytes take the written value; untouched bytes keep counting.
   always_comb begin
      timer_d = timer_q + 32'd1;
      if (conf_wr && conf_off == OffTimer) begin
         timer_d = byte_merge(timer_q + 32'd1, data_sram_wdata, data_sram_we);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) timer_q <= '0;
      else       timer_q <= timer_d;
   end
`endif

   always_comb begin
      led_d     = led_q;
      num_d     = num_q;
      scratch_d = scratch_q;
      if (conf_wr) begin
         case (conf_off)
            OffLed: begin
               if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
               if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
            end
            OffNum:     num_d     = byte_merge(num_q, data_sram_wdata, data_sram_we);
            OffScratch: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_we);
            default: ;
         endcase
      end
   end

   always_comb begin
      conf_rdata = '0;
      case (conf_off)
         OffLed:     conf_rdata = {16'h0000, led_q};
         OffSwitch:  conf_rdata = {24'h00_0000, sw_sync_q};
         OffNum:     conf_rdata = num_q;
`ifdef CONFREG_TIMER_EN
         OffTimer:   conf_rdata = timer_q;
`endif
         OffScratch: conf_rdata = scratch_q;
         default:    conf_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q     <= 16'hFFFF;
         num_q     <= '0;
         scratch_q <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         led_q     <= led_d;
         num_q     <= num_d;
         scratch_q <= scratch_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
      end
   end

   // ---------------------------------------------------------------- read port
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (data_sram_en) begin
         rdata_q <= conf_hit ? conf_rdata : ram_rdata;
      end
   end

   assign data_sram_rdata = rdata_q;
   assign led             = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: a per-cycle reference model plus literal spot checks.
// Honours CONFREG_TIMER_EN the same way the design does.
module tb_data_sram_resp;

   localparam int unsigned AddrW = 12;
   localparam int unsigned Depth = 1 << AddrW;

`ifdef CONFREG_TIMER_EN
   localparam logic [31:0] TimerRd0 = 32'hFFFF_FFFF;
   localparam logic [31:0] TimerRd1 = 32'h0000_0000;
`else
   localparam logic [31:0] TimerRd0 = 32'h0000_0000;
   localparam logic [31:0] TimerRd1 = 32'h0000_0000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] led;
   logic [7:0]  switch;

   int n_cmp = 0;
   int n_err = 0;

   data_sram_resp #(
      .ADDR_W    (AddrW),
      .CONF_BASE (32'hBFAF_0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (en),
      .data_sram_we    (we),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .led             (led),
      .switch          (switch)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   logic [31:0] mem_m [int unsigned];
   logic [15:0] m_led;
   logic [31:0] m_num, m_scratch, m_timer;
   logic [7:0]  m_s1, m_s2;
   logic [31:0] exp_rdata;
   bit          exp_valid = 0;
   bit          model_on  = 0;

   function automatic logic [31:0] apply_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_val;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      logic [31:0] rd;
      logic [31:0] t_next;
      int unsigned idx;
      bit rd_known;
      if (reset) begin
         exp_rdata = 32'h0;
         exp_valid = 1;
         model_on  = 1;
         m_led     = 16'hFFFF;
         m_num     = 32'h0;
         m_scratch = 32'h0;
         m_timer   = 32'h0;
         m_s1      = 8'h0;
         m_s2      = 8'h0;
      end else if (model_on) begin
         t_next   = m_timer + 32'd1;
         rd       = 32'h0;
         rd_known = 1;
         if (en) begin
            if (addr[31:16] == 16'hBFAF) begin
               case (addr[15:0] & 16'hFFFC)
                  16'h0000: rd = {16'h0, m_led};
                  16'h0004: rd = {24'h0, m_s2};
                  16'h0008: rd = m_num;
`ifdef CONFREG_TIMER_EN
                  16'h000C: rd = m_timer;
`endif
                  16'h0010: rd = m_scratch;
                  default:  rd = 32'h0;
               endcase
               if (we != 4'h0) begin
                  case (addr[15:0] & 16'hFFFC)
                     16'h0000: m_led = 16'(apply_bytes({16'h0, m_led}, wdata, {2'b00, we[1:0]}));
                     16'h0008: m_num = apply_bytes(m_num, wdata, we);
`ifdef CONFREG_TIMER_EN
                     16'h000C: t_next = apply_bytes(t_next, wdata, we);
`endif
                     16'h0010: m_scratch = apply_bytes(m_scratch, wdata, we);
                     default: ;
                  endcase
               end
            end else begin
               idx = (addr / 4) % Depth;
               rd_known = mem_m.exists(idx);
               if (rd_known) rd = mem_m[idx];
               if (we != 4'h0) begin
                  if (rd_known) mem_m[idx] = apply_bytes(mem_m[idx], wdata, we);
                  else if (we == 4'hF) mem_m[idx] = wdata;
               end
            end
            exp_rdata = rd;
            exp_valid = rd_known;
         end
         m_s2 = m_s1;
         m_s1 = switch;
`ifdef CONFREG_TIMER_EN
         m_timer = t_next;
`endif
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         if (exp_valid) check("rdata_vs_model", rdata, exp_rdata);
         check("led_vs_model", {16'h0, led}, {16'h0, m_led});
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      en = 1'b1; we = w; addr = a; wdata = d;
   endtask

   task automatic idle();
      @(negedge clk);
      en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; switch = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_rdata", rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0000_FFFF);
      reset = 1'b0;

      // Request during reset is dropped.
      req(4'hF, 32'h0000_0100, 32'h1234_5678);
      req(4'hF, 32'h0000_0100, 32'hFFFF_FFFF);
      reset = 1'b1;
      idle();
      check("reset_drop_rdata", rdata, 32'h0);
      reset = 1'b0;
      req(4'h0, 32'h0000_0100, 32'h0);
      idle();
      check("reset_drop_nowrite", rdata, 32'h1234_5678);

      // Full and byte writes.
      req(4'hF, 32'h0000_0040, 32'h1122_3344);
      req(4'h0, 32'h0000_0040, 32'h0);
      idle();
      check("ram_full_write", rdata, 32'h1122_3344);
      req(4'b0010, 32'h0000_0040, 32'hAABB_CCDD);
      req(4'h0, 32'h0000_0040, 32'h0);
      idle();
      check("ram_byte_write", rdata, 32'h1122_CC44);
      repeat (3) idle();
      check("en0_holds", rdata, 32'h1122_CC44);

      // Read-before-write then back-to-back.
      req(4'hF, 32'h0000_0080, 32'h0000_0009);
      req(4'hF, 32'h0000_0080, 32'h0000_0005);
      req(4'h0, 32'h0000_0080, 32'h0);
      check("simul_rbw", rdata, 32'h0000_0009);
      idle();
      check("b2b_new", rdata, 32'h0000_0005);

      // Upper RAM address bits alias.
      req(4'hF, 32'h0000_4040, 32'hCAFE_F00D);
      req(4'h0, 32'h0000_0040, 32'h0);
      idle();
      check("ram_alias", rdata, 32'hCAFE_F00D);

      // LED: low two bytes only.
      req(4'h3, 32'hBFAF_0000, 32'h0000_A5A5);
      idle();
      check("led_write", {16'h0, led}, 32'h0000_A5A5);
      req(4'hC, 32'hBFAF_0000, 32'hFFFF_0000);
      req(4'h0, 32'hBFAF_0000, 32'h0);
      idle();
      check("led_read", rdata, 32'h0000_A5A5);

      // Switch synchroniser, read-only.
      switch = 8'h3C;
      idle();
      idle();
      req(4'hF, 32'hBFAF_0004, 32'hFFFF_FFFF);
      req(4'h0, 32'hBFAF_0004, 32'h0);
      idle();
      check("switch_read", rdata, 32'h0000_003C);

      // Unmapped offset.
      req(4'hF, 32'hBFAF_0020, 32'h1234_5678);
      req(4'h0, 32'hBFAF_0020, 32'h0);
      idle();
      check("unmapped_read", rdata, 32'h0);

      // NUM and SCRATCH.
      req(4'hF, 32'hBFAF_0008, 32'hDEAD_BEEF);
      req(4'hF, 32'hBFAF_0010, 32'h1122_3344);
      req(4'b1001, 32'hBFAF_0010, 32'hAABB_CCDD);
      req(4'h0, 32'hBFAF_0008, 32'h0);
      req(4'h0, 32'hBFAF_0010, 32'h0);
      check("num_read", rdata, 32'hDEAD_BEEF);
      idle();
      check("scratch_byte", rdata, 32'hAA22_33DD);

      // TIMER wrap.
      req(4'hF, 32'hBFAF_000C, 32'hFFFF_FFFE);
      idle();
      req(4'h0, 32'hBFAF_000C, 32'h0);
      req(4'h0, 32'hBFAF_000C, 32'h0);
      check("timer_rd0", rdata, TimerRd0);
      idle();
      check("timer_rd1", rdata, TimerRd1);
      repeat (3) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 12: RAM depth is 2**ADDR_W 32-bit words.
REQ-002 Parameter CONF_BASE, default 32'hBFAF_0000: base of the config-register window; only bits [31:16] are compared.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_sram_en  input  1  request valid this cycle.
REQ-006 data_sram_we  input  4  byte write enables; all zero means read.
REQ-007 data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 data_sram_wdata  input  32  write data, byte lanes matching we.
REQ-009 data_sram_rdata  output  32  registered read data.
REQ-010 led  output  16  LED register contents.
REQ-011 switch  input  8  asynchronous board switches.

Function
REQ-012 Decode: CONF hit when addr[31:16]==CONF_BASE[31:16]; otherwise RAM, indexed by addr[ADDR_W+1:2]; higher RAM address bits are ignored (aliasing).
REQ-013 Write: en=1 and we!=0 updates only the bytes of the selected word/register whose we bit is set, at the clock edge.
REQ-014 Read latency exactly 1: when en=1, rdata at the next edge equals the pre-write contents of the addressed location (read-before-write), for both reads and writes.
REQ-015 en=0: rdata holds its previous value; no state changes except TIMER and the switch synchroniser.
REQ-016 Back-to-back: a write at cycle N followed by a read of the same address at N+1 returns the new data at N+2.
REQ-017 CONF offsets (addr[15:0]): 0x0000 LED RW [15:0], upper bytes read 0; 0x0004 SWITCH RO, zero-extended; 0x0008 NUM RW 32-bit; 0x000C TIMER; 0x0010 SCRATCH RW 32-bit.
REQ-018 Unmapped CONF offsets read 0; writes to them and to SWITCH are ignored.
REQ-019 switch passes through a 2-flop synchroniser; SWITCH reads return the second flop.
REQ-020 led output is driven directly from the LED register, so a write takes effect at the next edge.

Reset
REQ-021 reset=1 at an edge: rdata=0, LED=16'hFFFF, NUM=0, SCRATCH=0, TIMER=0, synchroniser flops=0.
REQ-022 RAM contents are not reset.
REQ-023 A request presented in the same cycle as reset is dropped: no write occurs and rdata=0.

Configuration
REQ-024 With macro CONFREG_TIMER_EN defined: TIMER is a 32-bit free-running counter, +1 per cycle, wrapping from 32'hFFFF_FFFF to 0.
REQ-025 When a TIMER write coincides with the increment, the written bytes take the written value and the unwritten bytes take the incremented value; the increment is not applied to the written bytes that cycle.
REQ-026 Without CONFREG_TIMER_EN: no counter is built, offset 0x000C behaves as unmapped (reads 0, writes ignored), and all other behaviour is unchanged.

Verification
REQ-027 Write 0x1122_3344 with we=4'hF at 0x0000_0040, then read 0x40 -> rdata=0x1122_3344 one cycle after the read request.
REQ-028 Byte write: we=4'b0010, wdata=0xAABB_CCDD to the same word, then read -> 0x1122_CC44.
REQ-029 Simultaneous access: write 0x5 to 0x80 and, in the same cycle, read 0x80 while it holds 0x9 -> rdata=0x9; a read at the next cycle -> 0x5.
REQ-030 LED: after reset led=0xFFFF; write 0x0000_A5A5 with we=4'h3 to 0xBFAF_0000 -> led=0xA5A5; a read returns 0x0000_A5A5.
REQ-031 Switch=8'h3C held for 2 cycles, then read 0xBFAF_0004 -> 0x0000_003C; a read of 0xBFAF_0020 -> 0.
REQ-032 With CONFREG_TIMER_EN: write 0xFFFF_FFFE to TIMER, then read twice on consecutive cycles -> 0xFFFF_FFFF, then 0x0000_0000. Without the macro -> both reads return 0.
